// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with boot/run/halt control,
// prioritised trap/mret/branch redirects, EPC capture and a fetch counter.
module pc_sequencer #(
    parameter int AddrSize = 32,
    parameter logic [AddrSize-1:0] ResetVector = '0,
    parameter logic [AddrSize-1:0] TrapVector = AddrSize'(32'h0000_0100),
    parameter int InstrBytes = 4,
    parameter int CountWidth = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_ready,
    input  logic                  redirect_valid,
    input  logic [AddrSize-1:0]   redirect_target,
    input  logic                  trap_req,
    input  logic [AddrSize-1:0]   trap_pc,
    input  logic                  mret_req,
    input  logic                  halt_req,
    input  logic                  resume_req,
    output logic [AddrSize-1:0]   PC_Curr,
    output logic [AddrSize-1:0]   PC_Plus,
    output logic                  fetch_valid,
    output logic [AddrSize-1:0]   epc,
    output logic                  trap_taken,
    output logic                  misalign_err,
    output logic                  halted,
    output logic [CountWidth-1:0] fetch_count
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
    state_e state_q, state_d;
    logic [AddrSize-1:0] pc_q, pc_d, epc_q, epc_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic tt_q, tt_d, me_q, me_d;
    logic run, accept, misaligned, bad_redirect, trap_go;
    always_comb begin
        run = state_q == RUN;
        accept = run && fetch_ready;
        misaligned = (InstrBytes == 4) ? |redirect_target[1:0] : redirect_target[0];
        // a misaligned branch only matters when neither trap nor mret outranks it
        bad_redirect = run && !trap_req && !mret_req && redirect_valid && misaligned;
        trap_go = (run && trap_req) || bad_redirect;
        pc_d = !run ? pc_q :
               trap_go ? TrapVector :
               mret_req ? epc_q :
               redirect_valid ? redirect_target :
               fetch_ready ? PC_Plus : pc_q;
        epc_d = trap_go ? trap_pc : epc_q;
        cnt_d = cnt_q + CountWidth'(accept);
        tt_d = trap_go;
        me_d = bad_redirect;
        state_d = (state_q == BOOT) ? RUN :
                  run ? (halt_req ? HALT : RUN) :
                  (resume_req && !halt_req) ? RUN : HALT;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q <= ResetVector;
            epc_q <= '0;
            cnt_q <= '0;
            tt_q <= 1'b0;
            me_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            epc_q <= epc_d;
            cnt_q <= cnt_d;
            tt_q <= tt_d;
            me_q <= me_d;
        end
    end
    assign PC_Curr = pc_q;
    assign PC_Plus = pc_q + AddrSize'(InstrBytes);
    assign fetch_valid = state_q == RUN;
    assign halted = state_q == HALT;
    assign epc = epc_q;
    assign trap_taken = tt_q;
    assign misalign_err = me_q;
    assign fetch_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for the 32-bit sequencer plus an
// 8-bit instance exercising PC wrap-around and asynchronous reset.
module tb_pc_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, fetch_ready, redirect_valid, trap_req, mret_req, halt_req, resume_req;
    logic [31:0] redirect_target, trap_pc;
    logic [31:0] pc_curr, pc_plus, epc, fetch_count;
    logic fetch_valid, trap_taken, misalign_err, halted;
    logic reset2;
    logic [7:0] pc2, plus2, epc2, cnt2;
    logic fv2, tt2, me2, h2;
    pc_sequencer dut (
        .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_req(trap_req), .trap_pc(trap_pc), .mret_req(mret_req),
        .halt_req(halt_req), .resume_req(resume_req),
        .PC_Curr(pc_curr), .PC_Plus(pc_plus), .fetch_valid(fetch_valid),
        .epc(epc), .trap_taken(trap_taken), .misalign_err(misalign_err),
        .halted(halted), .fetch_count(fetch_count)
    );
    pc_sequencer #(.AddrSize(8), .ResetVector(8'hF8), .TrapVector(8'h80), .CountWidth(8)) dut8 (
        .clk(clk), .reset(reset2), .fetch_ready(1'b1),
        .redirect_valid(1'b0), .redirect_target(8'h00),
        .trap_req(1'b0), .trap_pc(8'h00), .mret_req(1'b0),
        .halt_req(1'b0), .resume_req(1'b0),
        .PC_Curr(pc2), .PC_Plus(plus2), .fetch_valid(fv2),
        .epc(epc2), .trap_taken(tt2), .misalign_err(me2),
        .halted(h2), .fetch_count(cnt2)
    );
    typedef struct {
        string tag;
        logic [31:0] pc, epc, cnt;
        logic fv, tt, me, h;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic push(input string tag, input logic [31:0] pc, epc_e, cnt,
                        input logic fv, tt, me, h);
        sb.push_back('{tag, pc, epc_e, cnt, fv, tt, me, h});
    endtask
    task automatic check_st();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".pc"}, pc_curr, e.pc);
            cmp({e.tag, ".pc_plus"}, pc_plus, e.pc + 32'd4);
            cmp({e.tag, ".epc"}, epc, e.epc);
            cmp({e.tag, ".count"}, fetch_count, e.cnt);
            cmp({e.tag, ".fetch_valid"}, 32'(fetch_valid), 32'(e.fv));
            cmp({e.tag, ".trap_taken"}, 32'(trap_taken), 32'(e.tt));
            cmp({e.tag, ".misalign"}, 32'(misalign_err), 32'(e.me));
            cmp({e.tag, ".halted"}, 32'(halted), 32'(e.h));
        end
    endtask
    task automatic step(input string tag, input logic [31:0] pc, epc_e, cnt,
                        input logic fv, tt, me, h);
        push(tag, pc, epc_e, cnt, fv, tt, me, h);
        @(posedge clk);
        #1;
        check_st();
    endtask
    task automatic idle();
        redirect_valid = 0; trap_req = 0; mret_req = 0; halt_req = 0; resume_req = 0;
    endtask
    initial begin
        reset = 1; reset2 = 1; fetch_ready = 1; idle();
        redirect_target = 0; trap_pc = 0;
        #2;
        push("reset", 0, 0, 0, 0, 0, 0, 0);
        check_st();
        reset = 0;
        step("boot", 32'h0, 0, 0, 1, 0, 0, 0);
        step("seq1", 32'h4, 0, 1, 1, 0, 0, 0);
        step("seq2", 32'h8, 0, 2, 1, 0, 0, 0);
        step("seq3", 32'hC, 0, 3, 1, 0, 0, 0);
        step("seq4", 32'h10, 0, 4, 1, 0, 0, 0);
        fetch_ready = 0;
        for (int i = 0; i < 3; i++) step("stall", 32'h10, 0, 4, 1, 0, 0, 0);
        fetch_ready = 1;
        step("unstall", 32'h14, 0, 5, 1, 0, 0, 0);
        trap_req = 1; trap_pc = 32'h20; mret_req = 1; redirect_valid = 1; redirect_target = 32'h80;
        step("trap_prio", 32'h100, 32'h20, 6, 1, 1, 0, 0);
        idle(); fetch_ready = 0; mret_req = 1;
        step("mret", 32'h20, 32'h20, 6, 1, 0, 0, 0);
        idle(); redirect_valid = 1; redirect_target = 32'h42; trap_pc = 32'h30;
        step("misalign", 32'h100, 32'h30, 6, 1, 1, 1, 0);
        idle();
        step("pulse_end", 32'h100, 32'h30, 6, 1, 0, 0, 0);
        redirect_valid = 1; redirect_target = 32'h40;
        step("branch", 32'h40, 32'h30, 6, 1, 0, 0, 0);
        idle(); fetch_ready = 1; halt_req = 1;
        step("halt", 32'h44, 32'h30, 7, 0, 0, 0, 1);
        idle(); trap_req = 1; trap_pc = 32'h99;
        step("halt_trap", 32'h44, 32'h30, 7, 0, 0, 0, 1);
        idle(); resume_req = 1; halt_req = 1;
        step("halt_wins", 32'h44, 32'h30, 7, 0, 0, 0, 1);
        idle(); resume_req = 1; fetch_ready = 0;
        step("resume", 32'h44, 32'h30, 7, 1, 0, 0, 0);
        idle(); fetch_ready = 1;
        step("refetch", 32'h48, 32'h30, 8, 1, 0, 0, 0);
        #2 reset = 1;
        #1;
        push("async_reset", 0, 0, 0, 0, 0, 0, 0);
        check_st();
        reset2 = 0;
        @(posedge clk); #1;
        cmp("w8.boot_pc", 32'(pc2), 32'hF8);
        @(posedge clk); #1;
        cmp("w8.pc_fc", 32'(pc2), 32'hFC);
        cmp("w8.plus_wrap", 32'(plus2), 32'h00);
        @(posedge clk); #1;
        cmp("w8.wrap_pc", 32'(pc2), 32'h00);
        cmp("w8.count", 32'(cnt2), 32'h2);
        #3 reset2 = 1;
        #1;
        cmp("w8.async_pc", 32'(pc2), 32'hF8);
        cmp("w8.async_fv", 32'(fv2), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the RV32IM core; sits at the head of the fetch stage.
- Replaces the plain PC register with a controller that owns:
  - the reset vector;
  - a fetch valid/ready handshake to instruction memory;
  - prioritised redirects (trap, mret, branch/jump);
  - an exception PC register;
  - misaligned-target detection;
  - halt/resume control;
  - a fetch counter.

Parameters:
- AddrSize, 32, width of PC, targets and EPC.
- ResetVector, 32'h0000_0000, PC value loaded on reset.
- TrapVector, 32'h0000_0100, PC loaded on trap entry.
- InstrBytes, 4, sequential increment; legal values are 2 and 4.
- CountWidth, 32, width of fetch_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_ready  input  1  instruction memory accepts the current PC.
- redirect_valid  input  1  branch/jump taken from execute.
- redirect_target  input  AddrSize  branch/jump target.
- trap_req  input  1  synchronous exception/interrupt request.
- trap_pc  input  AddrSize  PC of the faulting or branching instruction; captured into EPC.
- mret_req  input  1  return from trap.
- halt_req  input  1  request to stop fetching.
- resume_req  input  1  leave HALT.
- PC_Curr  output  AddrSize  current fetch address.
- PC_Plus  output  AddrSize  combinational PC_Curr + InstrBytes, modulo 2^AddrSize.
- fetch_valid  output  1  PC_Curr is a valid fetch request.
- epc  output  AddrSize  exception PC register.
- trap_taken  output  1  one-cycle pulse, trap entry occurred this edge.
- misalign_err  output  1  one-cycle pulse, redirect target misaligned.
- halted  output  1  high in HALT.
- fetch_count  output  CountWidth  number of accepted fetches, wraps.

Behaviour:
- Reset (asynchronous, immediate):
  - PC_Curr=ResetVector, epc=0, fetch_count=0;
  - trap_taken=0, misalign_err=0;
  - state=BOOT, fetch_valid=0, halted=0.
- States:
  - BOOT: first rising edge with reset low goes to RUN; no other action is taken, and all requests are ignored.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, halted=1. PC and epc hold. trap_req, mret_req and redirect_valid are ignored. resume_req moves to RUN on the next edge.
- RUN next-PC priority, evaluated each edge, highest first:
  1. trap_req: epc<=trap_pc, PC_Curr<=TrapVector, trap_taken pulses.
  2. mret_req: PC_Curr<=epc.
  3. redirect_valid with aligned target: PC_Curr<=redirect_target.
     - Aligned means redirect_target[1:0]==0 when InstrBytes=4, and redirect_target[0]==0 when InstrBytes=2.
  4. redirect_valid with misaligned target: treated as a trap. epc<=trap_pc, PC_Curr<=TrapVector, trap_taken and misalign_err both pulse.
  5. fetch_valid && fetch_ready: PC_Curr<=PC_Plus.
  6. Otherwise: hold.
- Handshake:
  - A fetch is accepted on an edge where fetch_valid && fetch_ready.
  - fetch_count increments by 1 on each accepted fetch, including when a redirect overrides the next PC. It wraps at 2^CountWidth.
  - While fetch_ready=0 and no redirect is pending, PC_Curr stays stable.
- Halt:
  - halt_req in RUN moves to HALT on the same edge; any RUN PC update on that edge still applies.
  - A fetch accepted on that edge still counts.
  - resume_req and halt_req together in HALT: stay in HALT (halt wins).
- Wrap-around: the PC at 2^AddrSize-InstrBytes advances to 0 with no flag.
- trap_taken and misalign_err are registered, high for exactly one cycle after the causing edge, and 0 otherwise.
- Reset asserted mid-operation overrides everything asynchronously; epc is cleared.

Test Plan:
- Reset then release; fetch_ready=1 -> BOOT for 1 cycle with fetch_valid=0. PC_Curr then 0x0, 0x4, 0x8, and fetch_count counts 1, 2, 3.
- fetch_ready low for 3 cycles at PC=0x10 -> PC_Curr holds 0x10 and fetch_count holds. On release, PC=0x14.
- Same cycle: trap_req=1 (trap_pc=0x20), mret_req=1, redirect_valid=1 (target 0x80) -> PC=0x100, epc=0x20, trap_taken pulses once. A following mret_req -> PC=0x20.
- redirect_valid with target 0x42, trap_pc=0x30 -> PC=0x100, epc=0x30, misalign_err and trap_taken each high for exactly one cycle.
- halt_req at PC=0x40 with fetch_ready=1 -> PC=0x44, then halted=1 and fetch_valid=0. A trap_req during HALT is ignored. resume_req -> RUN, fetching resumes at 0x44.
- AddrSize=8, PC=0xFC, fetch_ready=1 -> next PC=0x00. Assert reset mid-cycle -> PC_Curr=ResetVector immediately, with no clock edge required.
